// File: rtl/ifstage_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage: default geometry,
// reset PC and the next-PC select encoding used by the PC register.
package ifstage_prefetch_pkg;

   localparam int          DEF_PC_W     = 32;
   localparam int          DEF_INSTR_W  = 32;
   localparam int          DEF_DEPTH    = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0;

   typedef enum logic [1:0] {
      NPC_HOLD     = 2'd0,
      NPC_SEQ      = 2'd1,
      NPC_REDIRECT = 2'd2
   } npc_sel_e;

   // INSTR_BYTES for a given instruction width; the PC step and alignment granule.
   function automatic int instr_bytes(input int instr_w);
      return instr_w / 8;
   endfunction

endpackage

// File: rtl/ifstage_prefetch_fetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer of {instr, pc} with push/pop/flush.
// The head entry is presented straight from storage; an empty queue reads as zero.
module ifstage_prefetch_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [W-1:0]           data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [W-1:0]           data_o,
   output logic                   valid_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int             PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             pop_eff;

   assign valid_o = (count_q != '0);
   assign pop_eff = pop_i && valid_o;
   assign count_o = count_q;
   assign data_o  = valid_o ? mem_q[rd_q] : '0;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush_i) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push_i)  wr_d = wr_q + PTR_ONE;
         if (pop_eff) rd_d = rd_q + PTR_ONE;
         case ({push_i, pop_eff})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
   end

   // The fetch credit check must never let a push land on a full queue.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && !flush_i && !pop_eff && count_q == FULL));

endmodule

// File: rtl/ifstage_prefetch.sv
// Instruction-fetch stage: PC register, sequential/redirect next-PC, one IMEM read per
// cycle with credit-based flow control, and a prefetch queue drained by decode.
module ifstage_prefetch
   import ifstage_prefetch_pkg::*;
#(
   parameter int              PC_W     = DEF_PC_W,
   parameter int              INSTR_W  = DEF_INSTR_W,
   parameter int              DEPTH    = DEF_DEPTH,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               PC_LdEn,
   input  logic               Redirect,
   input  logic               Redirect_abs,
   input  logic [PC_W-1:0]    Redirect_base,
   input  logic [PC_W-1:0]    PC_Immed,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_rd,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] Instr,
   output logic [PC_W-1:0]    Instr_PC,
   output logic               Instr_valid,
   input  logic               Instr_ready
);

   localparam int              IB         = instr_bytes(INSTR_W);
   localparam int              CNT_W      = $clog2(DEPTH) + 1;
   localparam int              QW         = INSTR_W + PC_W;
   localparam logic [PC_W-1:0] STEP       = PC_W'(IB);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(IB - 1));
   localparam logic [CNT_W:0]  DEPTH_L    = (CNT_W + 1)'(DEPTH);

   logic [PC_W-1:0]  pc_q, pc_d, tag_q, tag_d, target;
   logic             inflight_q, inflight_d;
   logic             issue, credit, push;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   logic [QW-1:0]    head;
   npc_sel_e         npc_sel;

   // Queued entries plus the outstanding read must fit, so a response always has a slot.
   assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
   assign credit    = occupancy < DEPTH_L;
   assign issue     = Reset && PC_LdEn && !Redirect && credit;
   assign push      = inflight_q && !Redirect;

   assign target = (Redirect_abs ? PC_Immed : Redirect_base + STEP + PC_Immed) & ALIGN_MASK;

   always_comb begin
      if (Redirect)   npc_sel = NPC_REDIRECT;
      else if (issue) npc_sel = NPC_SEQ;
      else            npc_sel = NPC_HOLD;
   end

   always_comb begin
      pc_d = pc_q;
      case (npc_sel)
         NPC_SEQ:      pc_d = pc_q + STEP;
         NPC_REDIRECT: pc_d = target;
         default:      pc_d = pc_q;
      endcase
   end

   assign inflight_d = issue;
   assign tag_d      = issue ? pc_q : tag_q;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
      end
   end

   // Redirect flushes the queue; any pop or response in that cycle is discarded.
   ifstage_prefetch_fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (QW)
   ) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Reset),
      .push_i  (push),
      .data_i  ({imem_rdata, tag_q}),
      .pop_i   (Instr_ready),
      .flush_i (Redirect),
      .data_o  (head),
      .valid_o (Instr_valid),
      .count_o (count)
   );

   assign imem_rd   = issue;
   assign imem_addr = pc_q;
   assign Instr     = head[QW-1:PC_W];
   assign Instr_PC  = head[PC_W-1:0];

endmodule

// File: tb/tb_ifstage_prefetch.sv
// Directed bench for ifstage_prefetch: a queue-level fetch model checked every cycle,
// plus hand-computed expectations for reset, stall, redirect, wrap and mid-stream reset.
module tb_ifstage_prefetch;

   localparam int          PC_W     = 32;
   localparam int          INSTR_W  = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        Clk;
   logic        Reset;
   logic        PC_LdEn;
   logic        Redirect;
   logic        Redirect_abs;
   logic [31:0] Redirect_base;
   logic [31:0] PC_Immed;
   logic [31:0] imem_addr;
   logic        imem_rd;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic [31:0] Instr_PC;
   logic        Instr_valid;
   logic        Instr_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   ifstage_prefetch #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .PC_LdEn       (PC_LdEn),
      .Redirect      (Redirect),
      .Redirect_abs  (Redirect_abs),
      .Redirect_base (Redirect_base),
      .PC_Immed      (PC_Immed),
      .imem_addr     (imem_addr),
      .imem_rd       (imem_rd),
      .imem_rdata    (imem_rdata),
      .Instr         (Instr),
      .Instr_PC      (Instr_PC),
      .Instr_valid   (Instr_valid),
      .Instr_ready   (Instr_ready)
   );

   // ---------------- clock / reset ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Instruction memory contents are a fixed scramble of the address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC3C3_3C3C;
   endfunction

   // Synchronous IMEM, one-cycle read latency.
   always @(posedge Clk) begin
      imem_rdata <= imem_rd ? mem_fn(imem_addr) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Queue of PCs the decode side should see, next fetch PC, and the outstanding read.
   logic [31:0] m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_tag;
   bit          m_inflight;
   bit          m_live = 0;

   function automatic bit exp_rd();
      return Reset && PC_LdEn && !Redirect && ((m_q.size() + int'(m_inflight)) < DEPTH);
   endfunction

   function automatic logic [31:0] exp_target();
      logic [31:0] t;
      t = Redirect_abs ? PC_Immed : Redirect_base + 32'd4 + PC_Immed;
      return (t / 32'd4) * 32'd4;
   endfunction

   initial begin
      forever begin
         @(posedge Clk);
         if (!Reset) begin
            m_q.delete();
            m_pc       = RESET_PC;
            m_inflight = 0;
            m_live     = 1;
         end else if (m_live) begin
            bit rd;
            rd = exp_rd();
            if (Redirect) begin
               m_q.delete();
               m_inflight = 0;
               m_pc       = exp_target();
            end else begin
               if (m_q.size() > 0 && Instr_ready) void'(m_q.pop_front());
               if (m_inflight) m_q.push_back(m_tag);
               if (m_q.size() > DEPTH) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL model_overflow at %0t: got %0d entries, limit %0d",
                           $time, m_q.size(), DEPTH);
               end
               m_inflight = rd;
               if (rd) begin
                  m_tag = m_pc;
                  m_pc  = m_pc + 32'd4;
               end
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   initial begin
      forever begin
         @(negedge Clk);
         if (m_live) begin
            chk("imem_rd", {31'b0, imem_rd}, {31'b0, exp_rd()});
            if (exp_rd()) chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", {31'b0, Instr_valid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) begin
               chk("instr_pc", Instr_PC, m_q[0]);
               chk("instr", Instr, mem_fn(m_q[0]));
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic redirect(input bit abs_mode, input logic [31:0] base, input logic [31:0] imm);
      tick();
      Redirect      = 1'b1;
      Redirect_abs  = abs_mode;
      Redirect_base = base;
      PC_Immed      = imm;
      @(negedge Clk);
      chk("redir_no_rd", {31'b0, imem_rd}, 32'd0);
      tick();
      Redirect = 1'b0;
   endtask

   initial begin
      Reset         = 1'b0;
      PC_LdEn       = 1'b0;
      Redirect      = 1'b0;
      Redirect_abs  = 1'b0;
      Redirect_base = '0;
      PC_Immed      = '0;
      Instr_ready   = 1'b0;
      repeat (3) tick();

      // Test 1: reset release, streaming 0,4,8,12 from cycle 2
      Reset       = 1'b1;
      PC_LdEn     = 1'b1;
      Instr_ready = 1'b1;
      @(negedge Clk);
      chk("t1_c0_rd", {31'b0, imem_rd}, 32'd1);
      chk("t1_c0_addr", imem_addr, 32'h0);
      chk("t1_c0_valid", {31'b0, Instr_valid}, 32'd0);
      chk("reset_instr", Instr, 32'h0);
      chk("reset_instr_pc", Instr_PC, 32'h0);
      tick();
      @(negedge Clk);
      chk("t1_c1_valid", {31'b0, Instr_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge Clk);
         chk("t1_stream_pc", Instr_PC, 32'(4 * i));
         chk("t1_stream_valid", {31'b0, Instr_valid}, 32'd1);
      end

      // Test 2: decode stalled for 10 cycles, queue holds exactly DEPTH entries
      tick();
      Instr_ready = 1'b0;
      repeat (9) tick();
      @(negedge Clk);
      chk("t2_full_rd", {31'b0, imem_rd}, 32'd0);
      chk("t2_full_head", Instr_PC, 32'h10);
      tick();
      Instr_ready = 1'b1;
      @(negedge Clk);
      chk("t2_drain0", Instr_PC, 32'h10);
      chk("t2_drain0_rd", {31'b0, imem_rd}, 32'd0);
      tick();
      @(negedge Clk);
      chk("t2_drain1", Instr_PC, 32'h14);
      chk("t2_resume_addr", imem_addr, 32'h20);
      tick();
      @(negedge Clk);
      chk("t2_drain2", Instr_PC, 32'h18);
      tick();
      @(negedge Clk);
      chk("t2_drain3", Instr_PC, 32'h1C);

      // Test 3: relative redirect, base 0x10 + 4 + 0x20 = 0x34
      redirect(1'b0, 32'h10, 32'h20);
      @(negedge Clk);
      chk("t3_flushed", {31'b0, Instr_valid}, 32'd0);
      chk("t3_issue_addr", imem_addr, 32'h34);
      tick();
      @(negedge Clk);
      chk("t3_still_empty", {31'b0, Instr_valid}, 32'd0);
      tick();
      @(negedge Clk);
      chk("t3_first_pc", Instr_PC, 32'h34);
      tick();
      @(negedge Clk);
      chk("t3_second_pc", Instr_PC, 32'h38);

      // Test 4: absolute redirect while a pop and a response are in progress
      redirect(1'b1, 32'hDEAD_0000, 32'h100);
      @(negedge Clk);
      chk("t4_flushed", {31'b0, Instr_valid}, 32'd0);
      tick();
      tick();
      @(negedge Clk);
      chk("t4_first_pc", Instr_PC, 32'h100);
      tick();
      @(negedge Clk);
      chk("t4_second_pc", Instr_PC, 32'h104);

      // Misaligned relative target: 0x1001 + 4 + 2 = 0x1007 -> 0x1004
      redirect(1'b0, 32'h1001, 32'h2);
      tick();
      tick();
      @(negedge Clk);
      chk("align_pc", Instr_PC, 32'h1004);

      // Test 5: PC wrap at the top of the address space
      redirect(1'b1, 32'h0, 32'hFFFF_FFFC);
      tick();
      tick();
      @(negedge Clk);
      chk("t5_top_pc", Instr_PC, 32'hFFFF_FFFC);
      tick();
      @(negedge Clk);
      chk("t5_wrap_pc", Instr_PC, 32'h0);
      tick();
      @(negedge Clk);
      chk("t5_after_wrap", Instr_PC, 32'h4);

      // Fetch stall with decode draining, then bursty decode
      for (int i = 0; i < 8; i++) begin
         tick();
         PC_LdEn     = 1'b0;
         Instr_ready = (i % 2) == 1;
      end
      @(negedge Clk);
      chk("stall_drained", {31'b0, Instr_valid}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         PC_LdEn     = 1'b1;
         Instr_ready = (i % 3) != 0;
      end

      // Mixed stall/ready pattern with two redirects
      for (int i = 0; i < 30; i++) begin
         tick();
         PC_LdEn       = (i % 5) != 4;
         Instr_ready   = (i % 3) != 1;
         Redirect      = (i == 11) || (i == 23);
         Redirect_abs  = (i == 23);
         Redirect_base = 32'h0000_2000;
         PC_Immed      = (i == 23) ? 32'h0000_0400 : 32'h0000_0010;
      end
      tick();
      Redirect = 1'b0;

      // Test 6: reset with the queue full, then restart at RESET_PC
      PC_LdEn     = 1'b1;
      Instr_ready = 1'b0;
      repeat (7) tick();
      @(negedge Clk);
      chk("t6_full_rd", {31'b0, imem_rd}, 32'd0);
      chk("t6_full_valid", {31'b0, Instr_valid}, 32'd1);
      tick();
      Reset = 1'b0;
      tick();
      Reset       = 1'b1;
      Instr_ready = 1'b1;
      @(negedge Clk);
      chk("t6_valid_cleared", {31'b0, Instr_valid}, 32'd0);
      chk("t6_restart_addr", imem_addr, RESET_PC);
      tick();
      tick();
      @(negedge Clk);
      chk("t6_restart_pc", Instr_PC, RESET_PC);
      tick();
      @(negedge Clk);
      chk("t6_restart_pc2", Instr_PC, RESET_PC + 32'd4);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
